sweep: RTL and testbench

- Registered triangle-wave (up/down ramp) generator for driving a DAC.
- A 32-bit signed fixed-point accumulator (16 integer bits, 16 fractional bits) ramps between minval_in and maxval_in by stepsize_in every clock, reversing direction at each limit.
- Sits between the control-register block and the DAC output path; signal_out is the integer part of the accumulator.

---
 rtl/sweep_pkg.sv | 21 ++
 rtl/sweep.sv | 107 ++++++++++
 tb/tb_sweep.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sweep_pkg.sv
// -----------------------------------------------------------------------------
// sweep_pkg
// Shared widths and direction encoding for the triangle-wave sweep generator.
//   OUT_W  : width of the signed integer part (output and limit width)
//   FRAC_W : fractional bits of the accumulator and the step
//   ACC_W  : accumulator width, 16.16 fixed point by default
//   EXT_W  : working width for step arithmetic; two guard bits so that
//            acc +/- step (step up to 2^32-1) can never wrap
//   DIR_UP / DIR_DOWN : encoding of the ramp direction register
// -----------------------------------------------------------------------------
package sweep_pkg;

    localparam int OUT_W  = 16;
    localparam int FRAC_W = 16;
    localparam int ACC_W  = OUT_W + FRAC_W;
    localparam int EXT_W  = ACC_W + 2;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : sweep_pkg

// File: rtl/sweep.sv
// -----------------------------------------------------------------------------
// sweep
// Registered triangle-wave generator feeding the DAC path. A signed 16.16
// accumulator ramps between minval_in and maxval_in by stepsize_in per clock
// and reverses direction exactly at each limit.
//
// Ports
//   clk_in      : system clock, rising edge
//   rst_n_in    : asynchronous active-low reset (acc = 0, direction up)
//   on_in       : sweep enable; low parks the accumulator at minval_in
//   minval_in   : lower limit, signed integer
//   maxval_in   : upper limit, signed integer
//   stepsize_in : unsigned step per clock, fixed point with FRAC_W fraction
//                 bits (bit 31 is magnitude, not sign)
//   signal_out  : integer part of the accumulator (truncated), registered
// -----------------------------------------------------------------------------
module sweep
    import sweep_pkg::*;
#(
    parameter int OUT_W  = sweep_pkg::OUT_W,
    parameter int FRAC_W = sweep_pkg::FRAC_W
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic                             on_in,
    input  logic signed [OUT_W-1:0]          minval_in,
    input  logic signed [OUT_W-1:0]          maxval_in,
    input  logic        [OUT_W+FRAC_W-1:0]   stepsize_in,
    output logic signed [OUT_W-1:0]          signal_out
);

    localparam int AW = OUT_W + FRAC_W;
    localparam int XW = AW + 2;

    // Architectural state: accumulator and ramp direction.
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 dir_q, dir_d;

    // Limits placed on the accumulator grid, plus extended copies for the
    // guarded arithmetic.
    logic signed [AW-1:0] min_acc, max_acc;
    logic signed [XW-1:0] acc_x, min_x, max_x, step_x, up_x, dn_x;

    assign min_acc = {minval_in, {FRAC_W{1'b0}}};
    assign max_acc = {maxval_in, {FRAC_W{1'b0}}};

    assign acc_x  = {{2{acc_q[AW-1]}}, acc_q};
    assign min_x  = {{2{min_acc[AW-1]}}, min_acc};
    assign max_x  = {{2{max_acc[AW-1]}}, max_acc};
    // Step is a magnitude: zero-extend so bit 31 never reads as a sign.
    assign step_x = {2'b00, stepsize_in};

    assign up_x = acc_x + step_x;
    assign dn_x = acc_x - step_x;

    // Next-state selection, highest priority first:
    //   disabled, degenerate window, above window, below window,
    //   zero step (hold, keep direction), then a normal step with clamp.
    always_comb begin
        acc_d = acc_q;
        dir_d = dir_q;
        if (!on_in) begin
            acc_d = min_acc;
            dir_d = DIR_UP;
        end else if (minval_in >= maxval_in) begin
            acc_d = min_acc;
            dir_d = DIR_UP;
        end else if (acc_x > max_x) begin
            acc_d = max_acc;
            dir_d = DIR_DOWN;
        end else if (acc_x < min_x) begin
            acc_d = min_acc;
            dir_d = DIR_UP;
        end else if (stepsize_in == '0) begin
            acc_d = acc_q;
            dir_d = dir_q;
        end else if (dir_q == DIR_UP) begin
            if (up_x >= max_x) begin
                acc_d = max_acc;
                dir_d = DIR_DOWN;
            end else begin
                acc_d = up_x[AW-1:0];
            end
        end else begin
            if (dn_x <= min_x) begin
                acc_d = min_acc;
                dir_d = DIR_UP;
            end else begin
                acc_d = dn_x[AW-1:0];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc_q <= '0;
            dir_q <= DIR_UP;
        end else begin
            acc_q <= acc_d;
            dir_q <= dir_d;
        end
    end

    // Output is the integer part of the registered accumulator (truncated).
    assign signal_out = acc_q[AW-1 -: OUT_W];

endmodule : sweep

// File: tb/tb_sweep.sv
module tb_sweep;

    logic               clk;
    logic               rst_n;
    logic               on;
    logic signed [15:0] minv;
    logic signed [15:0] maxv;
    logic        [31:0] step;
    logic signed [15:0] sig;

    int n_cmp = 0;
    int n_err = 0;

    sweep dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .on_in       (on),
        .minval_in   (minv),
        .maxval_in   (maxv),
        .stepsize_in (step),
        .signal_out  (sig)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [15:0] exp);
        n_cmp++;
        assert (sig === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, sig, exp);
        end
    endtask

    initial begin
        // 1. Reset with arbitrary inputs
        rst_n = 1'b0; on = 1'b1; minv = 16'sd77; maxv = 16'sd300; step = 32'h0001_0000;
        #1;
        check("rst_hold0", 16'sd0);
        tick(); check("rst_hold1", 16'sd0);
        tick(); check("rst_hold2", 16'sd0);
        rst_n = 1'b1; on = 1'b0; minv = 16'sd15;
        tick(); check("rst_release_min", 16'sd15);

        // 2. Half-LSB ramp up to full scale, then start back down
        maxv = 16'sd32767; step = 32'h0000_8000; on = 1'b1;
        tick(); check("half_e1", 16'sd15);
        tick(); check("half_e2", 16'sd16);
        repeat (65501) tick();
        check("half_e65503", 16'sd32766);
        tick(); check("half_e65504_max", 16'sd32767);
        tick(); check("half_dn1", 16'sd32766);
        tick(); check("half_dn2", 16'sd32766);
        tick(); check("half_dn3", 16'sd32765);

        // 3. Uneven step 3.0 between 0 and 10
        on = 1'b0; minv = 16'sd0; maxv = 16'sd10; step = 32'h0003_0000;
        tick(); check("uneven_park", 16'sd0);
        on = 1'b1;
        tick(); check("uneven_1", 16'sd3);
        tick(); check("uneven_2", 16'sd6);
        tick(); check("uneven_3", 16'sd9);
        tick(); check("uneven_4_max", 16'sd10);
        tick(); check("uneven_5", 16'sd7);
        tick(); check("uneven_6", 16'sd4);
        tick(); check("uneven_7", 16'sd1);
        tick(); check("uneven_8_min", 16'sd0);
        tick(); check("uneven_9", 16'sd3);
        tick(); check("uneven_10", 16'sd6);

        // Step with bit 31 set is a huge positive magnitude (32768.0)
        on = 1'b0; minv = -16'sd100; maxv = 16'sd100; step = 32'h8000_0000;
        tick(); check("bit31_park", -16'sd100);
        on = 1'b1;
        tick(); check("bit31_1", 16'sd100);
        tick(); check("bit31_2", -16'sd100);
        tick(); check("bit31_3", 16'sd100);

        // 4. Large step alternates min/max; degenerate window; zero step
        step = 32'h0100_0000;
        tick(); check("large_1", -16'sd100);
        tick(); check("large_2", 16'sd100);
        tick(); check("large_3", -16'sd100);
        minv = 16'sd5; maxv = 16'sd5;
        tick(); check("degen_1", 16'sd5);
        tick(); check("degen_2", 16'sd5);
        minv = -16'sd100; maxv = 16'sd100; step = 32'h0000_0000;
        tick(); check("zero_step_1", 16'sd5);
        tick(); check("zero_step_2", 16'sd5);
        tick(); check("zero_step_3", 16'sd5);

        // 5. Mid-sweep limit change: drop max below the accumulator
        on = 1'b0; minv = 16'sd500; maxv = 16'sd1000; step = 32'h0001_0000;
        tick(); check("mid_park", 16'sd500);
        on = 1'b1; minv = 16'sd0;
        tick(); check("mid_up1", 16'sd501);
        tick(); check("mid_up2", 16'sd502);
        maxv = 16'sd200;
        tick(); check("mid_clamp_max", 16'sd200);
        tick(); check("mid_dn1", 16'sd199);
        tick(); check("mid_dn2", 16'sd198);
        // Raise min above the accumulator: snap to min and head up
        minv = 16'sd250; maxv = 16'sd300;
        tick(); check("mid_clamp_min", 16'sd250);
        tick(); check("mid_up_after_min", 16'sd251);

        // 6. Disable mid-sweep, then async reset between edges
        on = 1'b0; minv = -16'sd7;
        tick(); check("off_1", -16'sd7);
        tick(); check("off_2", -16'sd7);
        on = 1'b1;
        tick(); check("on_again_1", -16'sd6);
        tick(); check("on_again_2", -16'sd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_now", 16'sd0);
        tick(); check("async_rst_held", 16'sd0);
        rst_n = 1'b1; on = 1'b0; minv = 16'sd15; maxv = 16'sd32767; step = 32'h0000_8000;
        tick(); check("post_rst_park", 16'sd15);
        on = 1'b1;
        tick(); check("post_rst_1", 16'sd15);
        tick(); check("post_rst_2", 16'sd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sweep
